seq_alu: RTL and testbench



---
 rtl/seq_alu_if.sv | 29 ++
 rtl/seq_alu.sv | 196 +++++++++++++++++++
 tb/tb_seq_alu.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_alu_if.sv
// seq_alu_if: operand/result handshake bundle for seq_alu.
//   IN_VALID/IN_READY    : operand handshake (producer -> unit)
//   DATA1, DATA2         : operands, ALU_OPERATION: 6-bit op select
//   OUT_VALID/OUT_READY  : result handshake (unit -> consumer)
//   RESULT               : registered result
// master = pipeline side driving operands and consuming results,
// slave  = the execution unit.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] DATA1;
    logic [WIDTH-1:0] DATA2;
    logic [5:0]       ALU_OPERATION;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] RESULT;

    modport master (
        output IN_VALID, DATA1, DATA2, ALU_OPERATION, OUT_READY,
        input  IN_READY, OUT_VALID, RESULT
    );

    modport slave (
        input  IN_VALID, DATA1, DATA2, ALU_OPERATION, OUT_READY,
        output IN_READY, OUT_VALID, RESULT
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle RV32IM integer execution unit.
//   CLK      : clock, rising edge
//   RESET_N  : asynchronous active-low reset
//   FLUSH    : synchronous abort of the in-flight op (beats any accept)
//   bus      : seq_alu_if slave (operand and result handshakes)
// Base ops finish at the accept edge, multiplies take MUL_LATENCY edges
// counting the accept edge, divides take WIDTH+2 edges (capture, WIDTH
// restoring iterations, one sign-fix cycle). Divide-by-zero and signed
// overflow complete like base ops.
module seq_alu #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 2
) (
    input logic     CLK,
    input logic     RESET_N,
    input logic     FLUSH,
    seq_alu_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(WIDTH + MUL_LATENCY + 1) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state_reg, state_next, start_state;
    logic [1:0]         op_sel_reg;      // low op bits select the mul/div variant
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [WIDTH-1:0]   quo_reg, dvs_reg, rem_reg;
    logic               neg_q_reg, neg_r_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               in_ready, out_valid, accept;

    function automatic logic [WIDTH-1:0] base_calc(input logic [5:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        logic [SH_W-1:0] sh;
        sh = b[SH_W-1:0];
        base_calc = '0;
        case (op)
            6'h00: base_calc = a & b;
            6'h01: base_calc = a | b;
            6'h02: base_calc = a + b;
            6'h03: base_calc = a - b;
            6'h04: base_calc = a << sh;
            6'h05: base_calc = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            6'h06: base_calc = {{(WIDTH-1){1'b0}}, a < b};
            6'h07: base_calc = a ^ b;
            6'h08: base_calc = a >> sh;
            6'h09: base_calc = $signed(a) >>> sh;
            default: base_calc = '0;
        endcase
    endfunction

    // sel: 00 MUL, 01 MULH (s x s), 10 MULHSU (s x u), 11 MULHU (u x u)
    function automatic logic [WIDTH-1:0] mul_calc(input logic [1:0] sel,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [2*WIDTH-1:0] ea, eb, p;
        ea = {{WIDTH{(sel != 2'b11) & a[WIDTH-1]}}, a};
        eb = {{WIDTH{(sel == 2'b01) & b[WIDTH-1]}}, b};
        p  = ea * eb;
        mul_calc = (sel == 2'b00) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    endfunction

    // Decode of the op presented on the bus; only used at the accept edge.
    logic [5:0]       in_op;
    logic             in_is_mul, in_is_div, in_div_signed, in_div_zero, in_div_ovf;
    logic [WIDTH-1:0] in_imm, in_special, a_mag, b_mag;

    always_comb begin
        in_op         = bus.ALU_OPERATION;
        in_is_mul     = (in_op[5:2] == 4'b0100);
        in_is_div     = (in_op[5:2] == 4'b0101);
        in_div_signed = ~in_op[0];
        in_div_zero   = (bus.DATA2 == '0);
        in_div_ovf    = in_div_signed & (bus.DATA1 == {1'b1, {(WIDTH-1){1'b0}}})
                        & (bus.DATA2 == '1);
        // op[1] set means REM/REMU
        if (in_div_zero)
            in_special = in_op[1] ? bus.DATA1 : '1;
        else
            in_special = in_op[1] ? '0 : bus.DATA1;
        if (in_is_mul)
            in_imm = mul_calc(in_op[1:0], bus.DATA1, bus.DATA2);
        else if (in_is_div)
            in_imm = in_special;
        else
            in_imm = base_calc(in_op, bus.DATA1, bus.DATA2);
        a_mag = (in_div_signed & bus.DATA1[WIDTH-1]) ? -bus.DATA1 : bus.DATA1;
        b_mag = (in_div_signed & bus.DATA2[WIDTH-1]) ? -bus.DATA2 : bus.DATA2;
        if (in_is_mul)
            start_state = (MUL_LATENCY == 1) ? DONE : MUL;
        else if (in_is_div && !(in_div_zero || in_div_ovf))
            start_state = DIV;
        else
            start_state = DONE;
    end

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        if (FLUSH) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (accept) state_next = start_state;
                MUL:  if (cnt_reg == CNT_W'(MUL_LATENCY - 1)) state_next = DONE;
                DIV:  if (cnt_reg == CNT_W'(WIDTH)) state_next = DONE;
                DONE: if (bus.OUT_READY) state_next = accept ? start_state : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output logic; OUT_READY -> IN_READY is the only combinational path.
    always_comb begin
        in_ready  = (state_reg == IDLE) | ((state_reg == DONE) & bus.OUT_READY);
        out_valid = (state_reg == DONE);
        accept    = bus.IN_VALID & in_ready & ~FLUSH;
    end

    assign bus.IN_READY  = in_ready;
    assign bus.OUT_VALID = out_valid;
    assign bus.RESULT    = result_reg;

    // One restoring-division step on magnitudes.
    logic [WIDTH:0] div_shift, div_trial;
    always_comb begin
        div_shift = {rem_reg, quo_reg[WIDTH-1]};
        div_trial = div_shift - {1'b0, dvs_reg};
    end

    // Datapath
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            op_sel_reg <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            quo_reg    <= '0;
            dvs_reg    <= '0;
            rem_reg    <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            cnt_reg    <= '0;
            result_reg <= '0;
        end else if (FLUSH) begin
            cnt_reg <= '0;
        end else if (accept) begin
            op_sel_reg <= in_op[1:0];
            a_reg      <= bus.DATA1;
            b_reg      <= bus.DATA2;
            quo_reg    <= a_mag;
            dvs_reg    <= b_mag;
            rem_reg    <= '0;
            neg_q_reg  <= in_div_signed & (bus.DATA1[WIDTH-1] ^ bus.DATA2[WIDTH-1]);
            neg_r_reg  <= in_div_signed & bus.DATA1[WIDTH-1];
            // the accept edge counts as the first multiply cycle
            cnt_reg    <= in_is_mul ? CNT_W'(1) : '0;
            if (start_state == DONE)
                result_reg <= in_imm;
        end else begin
            case (state_reg)
                MUL: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(MUL_LATENCY - 1))
                        result_reg <= mul_calc(op_sel_reg, a_reg, b_reg);
                end
                DIV: begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg != CNT_W'(WIDTH)) begin
                        if (div_trial[WIDTH]) begin
                            rem_reg <= div_shift[WIDTH-1:0];
                            quo_reg <= {quo_reg[WIDTH-2:0], 1'b0};
                        end else begin
                            rem_reg <= div_trial[WIDTH-1:0];
                            quo_reg <= {quo_reg[WIDTH-2:0], 1'b1};
                        end
                    end else begin
                        // sign-fix cycle
                        if (op_sel_reg[1])
                            result_reg <= neg_r_reg ? -rem_reg : rem_reg;
                        else
                            result_reg <= neg_q_reg ? -quo_reg : quo_reg;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    localparam int W  = 32;
    localparam int ML = 2;

    logic CLK     = 1'b0;
    logic RESET_N = 1'b0;
    logic FLUSH   = 1'b0;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W), .MUL_LATENCY(ML)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .FLUSH   (FLUSH),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] res;
        int          lat;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one op, queue its expectation, wait for the accept edge.
    task automatic send(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] r, input int lat);
        int tries;
        tries = 0;
        @(negedge CLK);
        bus.IN_VALID      = 1'b1;
        bus.ALU_OPERATION = op;
        bus.DATA1         = a;
        bus.DATA2         = b;
        sb_q.push_back('{res: r, lat: lat, name: name});
        while (!bus.IN_READY && tries < 50) begin
            @(negedge CLK);
            tries++;
        end
        check({name, "_accept"}, {31'b0, bus.IN_READY}, 32'd1);
        @(posedge CLK);
        #1;
        // scramble inputs: the in-flight op must not see them
        bus.IN_VALID      = 1'b0;
        bus.ALU_OPERATION = 6'h02;
        bus.DATA1         = $urandom;
        bus.DATA2         = $urandom;
    endtask

    // Wait for OUT_VALID (latency counted with the accept edge as 1) and score.
    task automatic collect();
        int   lat;
        exp_t e;
        lat = 1;
        while (!bus.OUT_VALID && lat < 60) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check(e.name, bus.RESULT, e.res);
            check({e.name, "_lat"}, lat, e.lat);
            $display("[TB] %s result=%h latency=%0d", e.name, bus.RESULT, lat);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb, held;
        int          seen;
        exp_t        e;

        bus.IN_VALID      = 1'b0;
        bus.OUT_READY     = 1'b1;
        bus.DATA1         = '0;
        bus.DATA2         = '0;
        bus.ALU_OPERATION = '0;

        vecs.push_back('{"add_ovf", 6'h02, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1});
        vecs.push_back('{"sra",     6'h09, 32'h80000000, 32'h00000024, 32'hF8000000, 1});
        vecs.push_back('{"and",     6'h00, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1});
        vecs.push_back('{"or",      6'h01, 32'h0000FFFF, 32'h12340000, 32'h1234FFFF, 1});
        vecs.push_back('{"sub",     6'h03, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1});
        vecs.push_back('{"sll",     6'h04, 32'h00000001, 32'h0000003F, 32'h80000000, 1});
        vecs.push_back('{"slt",     6'h05, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1});
        vecs.push_back('{"sltu",    6'h06, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1});
        vecs.push_back('{"xor",     6'h07, 32'hAAAAAAAA, 32'hFFFFFFFF, 32'h55555555, 1});
        vecs.push_back('{"srl",     6'h08, 32'h80000000, 32'h00000004, 32'h08000000, 1});
        vecs.push_back('{"undef",   6'h0A, 32'h12345678, 32'h11111111, 32'h00000000, 1});
        vecs.push_back('{"mul",     6'h10, 32'h12345678, 32'h00000010, 32'h23456780, ML});
        vecs.push_back('{"mulh",    6'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, ML});
        vecs.push_back('{"mulhu",   6'h13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ML});
        vecs.push_back('{"mulhsu",  6'h12, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, ML});
        vecs.push_back('{"div_neg", 6'h14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, W+2});
        vecs.push_back('{"rem_neg", 6'h16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, W+2});
        vecs.push_back('{"divu",    6'h15, 32'd100,      32'd7,        32'd14,       W+2});
        vecs.push_back('{"remu",    6'h17, 32'd100,      32'd7,        32'd2,        W+2});
        vecs.push_back('{"div_ndv", 6'h14, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, W+2});
        vecs.push_back('{"rem_ndv", 6'h16, 32'd7,        32'hFFFFFFFE, 32'h00000001, W+2});
        vecs.push_back('{"div_min", 6'h14, 32'h80000000, 32'h00000002, 32'hC0000000, W+2});
        vecs.push_back('{"div_z",   6'h14, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"rem_z",   6'h16, 32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{"divu_z",  6'h15, 32'd5,        32'd0,        32'hFFFFFFFF, 1});
        vecs.push_back('{"remu_z",  6'h17, 32'd5,        32'd0,        32'd5,        1});
        vecs.push_back('{"div_ovf", 6'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        vecs.push_back('{"rem_ovf", 6'h16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1});

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", {31'b0, bus.OUT_VALID}, 32'd0);
        check("rst_in_ready",  {31'b0, bus.IN_READY},  32'd1);
        check("rst_result",    bus.RESULT,             32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            send(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].lat);
            collect();
        end

        // Backpressure: let the last result drain, then stall the consumer
        @(posedge CLK);
        #1;
        bus.OUT_READY = 1'b0;
        send("bp_add", 6'h02, 32'h00001000, 32'h00000234, 32'h00001234, 1);
        collect();
        held = 32'h00001234;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK);
            #1;
            check("bp_hold_result", bus.RESULT, held);
            check("bp_in_ready",    {31'b0, bus.IN_READY},  32'd0);
            check("bp_out_valid",   {31'b0, bus.OUT_VALID}, 32'd1);
        end
        $display("[TB] bp_hold result=%h held 5 cycles", bus.RESULT);
        @(negedge CLK);
        bus.OUT_READY     = 1'b1;
        bus.IN_VALID      = 1'b1;
        bus.ALU_OPERATION = 6'h07;
        bus.DATA1         = 32'h0F0F0F0F;
        bus.DATA2         = 32'h00FF00FF;
        sb_q.push_back('{res: 32'h0FF00FF0, lat: 1, name: "bp_release_xor"});
        #1;
        check("bp_ready_comb", {31'b0, bus.IN_READY}, 32'd1);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        collect();

        // Back-to-back ADDs with OUT_READY high: one result per cycle
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            ra = $urandom;
            rb = $urandom;
            bus.IN_VALID      = 1'b1;
            bus.ALU_OPERATION = 6'h02;
            bus.DATA1         = ra;
            bus.DATA2         = rb;
            sb_q.push_back('{res: ra + rb, lat: 1, name: "b2b_add"});
            @(posedge CLK);
            #1;
            check("b2b_out_valid", {31'b0, bus.OUT_VALID}, 32'd1);
            e = sb_q.pop_front();
            check(e.name, bus.RESULT, e.res);
            $display("[TB] b2b_add %h+%h result=%h", ra, rb, bus.RESULT);
        end
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;

        // Flush 10 cycles into a DIV, with a competing op offered on the flush edge
        @(negedge CLK);
        bus.IN_VALID      = 1'b1;
        bus.ALU_OPERATION = 6'h14;
        bus.DATA1         = 32'd1000;
        bus.DATA2         = 32'd3;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        repeat (9) @(posedge CLK);
        @(negedge CLK);
        FLUSH             = 1'b1;
        bus.IN_VALID      = 1'b1;
        bus.ALU_OPERATION = 6'h02;
        bus.DATA1         = 32'd1;
        bus.DATA2         = 32'd2;
        @(posedge CLK);
        #1;
        FLUSH        = 1'b0;
        bus.IN_VALID = 1'b0;
        check("flush_out_valid", {31'b0, bus.OUT_VALID}, 32'd0);
        check("flush_in_ready",  {31'b0, bus.IN_READY},  32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (bus.OUT_VALID) seen = 1;
        end
        check("flush_no_valid", seen, 0);
        $display("[TB] flush_div out_valid_seen=%0d", seen);

        // Reset in the middle of a multiply
        @(negedge CLK);
        bus.IN_VALID      = 1'b1;
        bus.ALU_OPERATION = 6'h10;
        bus.DATA1         = 32'd3;
        bus.DATA2         = 32'd5;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        #1;
        RESET_N = 1'b0;
        #1;
        check("rstmul_out_valid", {31'b0, bus.OUT_VALID}, 32'd0);
        check("rstmul_in_ready",  {31'b0, bus.IN_READY},  32'd1);
        check("rstmul_result",    bus.RESULT,             32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        seen = 0;
        repeat (4) begin
            @(posedge CLK);
            #1;
            if (bus.OUT_VALID) seen = 1;
        end
        check("rstmul_no_valid", seen, 0);
        $display("[TB] reset_mid_mul out_valid_seen=%0d result=%h", seen, bus.RESULT);

        // Recovery after reset
        send("post_rst_mulhu", 6'h13, 32'h80000000, 32'h00000004, 32'h00000002, ML);
        collect();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
